sram_burst_arbiter: RTL and testbench
=====================================

// Module: sram_burst_arbiter
// PURPOSE
//  Shares the 16-bit SRAM burst controller (128-word read/write bursts) between
//  NREQ requesters (req 0 = video fetch, 1..NREQ-1 = cache/DMA).
//  Arbitrates and issues one-cycle burst commands.
//  Routes write data in and read/write beat strobes out to the granted requester.
//  Detects end of burst and guarantees an idle gap before the next command.
// PARAMETERS
//  NREQ          3   number of requesters (2..4)
//  QUIET         8   consecutive strobe-free cycles required in SYNC
//  START_TIMEOUT 8   max cycles from command issue to first beat strobe
//  GAP_CYCLES    2   idle cycles after burst end before next command
// PORTS
//  sys_CLK            in   1        clock
//  sys_RST            in   1        asynchronous reset, active high
//  req                in   NREQ     level request, held until req_ack
//  req_wr             in   NREQ     1 = write burst, 0 = read burst
//  req_addr           in   NREQ*19  word address per requester, [19*i +: 19]
//  req_din            in   NREQ*16  write data per requester, [16*i +: 16]
//  req_ack            out  NREQ     1-cycle pulse: command issued for requester i
//  req_rd_valid       out  NREQ     sys_rd_data_valid gated to granted requester
//  req_wr_valid       out  NREQ     sys_wr_data_valid gated to granted requester
//  req_done           out  NREQ     1-cycle pulse: granted burst finished
//  dout               out  16       sys_DOUT broadcast to all requesters
//  busy               out  1        high in every state except IDLE
//  err                out  1        1-cycle pulse on start timeout
//  sys_CMD            out  2        to controller: 00 nop, 01 write, 11 read
//  sys_ADDR           out  19       to controller: burst word address
//  sys_DIN            out  16       to controller: req_din of granted requester
//  sys_DOUT           in   16       from controller: read data
//  sys_rd_data_valid  in   1        from controller: read beat strobe
//  sys_wr_data_valid  in   1        from controller: write beat strobe
// BEHAVIOUR
//  Reset values (async, while sys_RST=1)
//   - State = SYNC; sys_CMD = 00; sys_ADDR = 0.
//   - req_ack = req_done = 0; err = 0; busy = 1.
//   - Grant one-hot = 0; RR pointer = 1.
//  Routing (combinational on the registered grant)
//   - With grant = 0: sys_DIN = 0, req_rd_valid = req_wr_valid = 0.
//  SYNC
//   - The controller has no reset, so the arbiter waits out any burst in flight.
//   - Counts consecutive cycles with rd_valid = wr_valid = 0.
//   - Any strobe clears the count; reaching QUIET -> IDLE.
//  IDLE
//   - If any req is set, pick a winner:
//     - req[0] has fixed priority.
//     - Otherwise round-robin over 1..NREQ-1, starting at the RR pointer.
//   - In the same cycle register:
//     - grant;
//     - sys_ADDR = req_addr[winner];
//     - sys_CMD = req_wr[winner] ? 01 : 11;
//     - req_ack[winner] = 1.
//   - Then -> START.
//   - If the winner is not 0, the RR pointer moves to the next index after the winner, wrapping NREQ-1 -> 1.
//  START
//   - sys_CMD returns to 00 on the first START cycle, so CMD is exactly 1 cycle wide.
//   - The first cycle with the expected strobe high (rd for read, wr for write) -> BURST.
//   - If START_TIMEOUT cycles pass with no strobe: err pulse, grant cleared, -> SYNC.
//  BURST
//   - Strobes pass through to the granted requester.
//   - First cycle with the expected strobe low: req_done[grant] pulse, grant cleared, -> GAP.
//  GAP
//   - Hold GAP_CYCLES cycles, then -> IDLE.
//   - A strobe seen in GAP forces -> SYNC.
//  Boundary rules
//   - Requester rules:
//     - A requester must drop req the cycle after req_ack, otherwise it is granted again.
//     - During a write it holds req_din valid and advances it per req_wr_valid beat.
//   - Requests raised in any state other than IDLE wait; there is no lost or queued pulse, since req is level.
//   - Several requests in the same IDLE cycle: exactly one ack.
//   - Reset during BURST: all outputs go to reset values at once, then SYNC absorbs the burst tail.
//   - sys_ADDR is held stable from issue until the next issue.
// TESTING
//  1. Reset, no strobes -> busy falls after 8+1 cycles; sys_CMD stays 00.
//  2. req=001, req_wr=0, addr 0x12345 -> one cycle of CMD=11 with ADDR=0x12345 and ack=001; 128 rd beats reach req_rd_valid[0] only; done=001; next CMD no sooner than 2 cycles later.
//  3. req=110 held, re-raised after each done -> grants alternate 1,2,1,2; req=111 -> requester 0 is granted first.
//  4. Write burst, req 2, din = beat index -> sys_DIN follows req_din[2]; req_wr_valid[2] mirrors the strobe; CMD=01.
//  5. Issue read, no strobe for 8 cycles -> err pulse, busy stays high through SYNC, then IDLE.
//  6. Assert sys_RST at beat 40 of a read -> outputs reset; the remaining 88 beats are not routed; no CMD until 8 quiet cycles.

Source files
------------

// File: rtl/sram_burst_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_burst_arbiter_if
// Purpose : Bundles the requester-side handshake and the SRAM burst controller
//           bus that the arbiter sits between.
// Modports:
//   slave  - arbiter view: requests and controller strobes in; acks, routed
//            strobes, burst command/address/write data out.
//   master - environment view (requesters + controller), the mirror image.
// Signals :
//   req, req_wr          per-requester level request and direction (1 = write)
//   req_addr, req_din    per-requester word address [19*i +: 19] and write data
//   req_ack, req_done    one-cycle pulses: command issued / burst finished
//   req_rd/wr_valid      controller beat strobes gated to the granted requester
//   dout                 controller read data broadcast to every requester
//   busy, err            arbiter not in IDLE / start-timeout pulse
//   sys_CMD/ADDR/DIN     command (00 nop, 01 write, 11 read), address, data
//   sys_DOUT, sys_*_valid read data and beat strobes from the controller
// -----------------------------------------------------------------------------
interface sram_burst_arbiter_if #(
    parameter int NREQ = 3
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*19-1:0] req_addr;
    logic [NREQ*16-1:0] req_din;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    req_rd_valid;
    logic [NREQ-1:0]    req_wr_valid;
    logic [NREQ-1:0]    req_done;
    logic [15:0]        dout;
    logic               busy;
    logic               err;
    logic [1:0]         sys_CMD;
    logic [18:0]        sys_ADDR;
    logic [15:0]        sys_DIN;
    logic [15:0]        sys_DOUT;
    logic               sys_rd_data_valid;
    logic               sys_wr_data_valid;

    modport slave (
        input  req, req_wr, req_addr, req_din,
        input  sys_DOUT, sys_rd_data_valid, sys_wr_data_valid,
        output req_ack, req_rd_valid, req_wr_valid, req_done, dout, busy, err,
        output sys_CMD, sys_ADDR, sys_DIN
    );

    modport master (
        output req, req_wr, req_addr, req_din,
        output sys_DOUT, sys_rd_data_valid, sys_wr_data_valid,
        input  req_ack, req_rd_valid, req_wr_valid, req_done, dout, busy, err,
        input  sys_CMD, sys_ADDR, sys_DIN
    );
endinterface

// File: rtl/sram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// sram_burst_arbiter
// Purpose : Shares one 16-bit SRAM burst controller (128-word bursts) between
//           NREQ requesters. Requester 0 (video fetch) has fixed priority, the
//           others are served round-robin. Issues a one-cycle burst command,
//           routes write data in and beat strobes out to the granted requester,
//           detects end of burst and enforces an idle gap before the next one.
//           The controller has no reset, so after reset (or any protocol upset)
//           the arbiter waits for QUIET+1 strobe-free cycles before arbitrating.
// Ports   :
//   sys_CLK  in  clock
//   sys_RST  in  asynchronous reset, active high
//   bus      slave modport of sram_burst_arbiter_if (requesters + controller)
// -----------------------------------------------------------------------------
module sram_burst_arbiter #(
    parameter int NREQ          = 3,
    parameter int QUIET         = 8,
    parameter int START_TIMEOUT = 8,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                sys_CLK,
    input  logic                sys_RST,
    sram_burst_arbiter_if.slave bus
);
    localparam int IDXW    = $clog2(NREQ);
    localparam int MAX_AB  = (QUIET > START_TIMEOUT) ? QUIET : START_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b11;

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_START,
        S_BURST,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;      // shared by SYNC (quiet), START (timeout), GAP
    logic [NREQ-1:0] grant_q;
    logic [IDXW-1:0] ptr_q;      // first round-robin candidate among 1..NREQ-1
    logic            is_wr_q;
    logic [1:0]      cmd_q;
    logic [18:0]     addr_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] done_q;
    logic            err_q;

    logic            any_strobe;
    logic            exp_strobe;
    int              win_int;
    logic            win_found;
    logic [NREQ-1:0] win_oh_d;
    logic [18:0]     win_addr_d;
    logic            win_wr_d;
    logic [IDXW-1:0] ptr_d;
    logic [15:0]     din_mux;

    assign any_strobe = bus.sys_rd_data_valid | bus.sys_wr_data_valid;
    assign exp_strobe = is_wr_q ? bus.sys_wr_data_valid : bus.sys_rd_data_valid;

    // Winner selection: requester 0 first, then 1..NREQ-1 scanned from ptr_q.
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        win_int    = 0;
        win_found  = 1'b0;
        if (bus.req[0]) begin
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                for (int i = 1; i < NREQ; i++) begin
                    if (!win_found && bus.req[i] &&
                        i == ((int'(ptr_q) - 1 + k) % (NREQ - 1)) + 1) begin
                        win_found = 1'b1;
                        win_int   = i;
                    end
                end
            end
        end

        win_oh_d   = '0;
        win_addr_d = '0;
        win_wr_d   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == win_int) begin
                win_oh_d[i] = 1'b1;
                win_addr_d  = bus.req_addr[19*i +: 19];
                win_wr_d    = bus.req_wr[i];
            end
        end

        // Pointer moves past the winner, wrapping NREQ-1 back to 1.
        ptr_d = (win_int == NREQ - 1) ? IDXW'(1) : IDXW'(win_int + 1);
    end

    // Write data of the granted requester; zero when nothing is granted.
    always_comb begin
        din_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                din_mux = din_mux | bus.req_din[16*i +: 16];
            end
        end
    end

    // NOTE: all state here is assigned with <= so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge sys_CLK or posedge sys_RST) begin
        if (sys_RST) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= IDXW'(1);
            is_wr_q <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // Pulse outputs default low; the states below raise them for one cycle.
            cmd_q  <= CMD_NOP;
            ack_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;

            case (state_q)
                S_SYNC: begin
                    if (any_strobe) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(QUIET)) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_IDLE: begin
                    if (|bus.req) begin
                        grant_q <= win_oh_d;
                        ack_q   <= win_oh_d;
                        addr_q  <= win_addr_d;
                        is_wr_q <= win_wr_d;
                        cmd_q   <= win_wr_d ? CMD_WR : CMD_RD;
                        if (win_int != 0) begin
                            ptr_q <= ptr_d;
                        end
                        cnt_q   <= '0;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (exp_strobe) begin
                        state_q <= S_BURST;
                    end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        cnt_q   <= '0;
                        state_q <= S_SYNC;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_BURST: begin
                    if (!exp_strobe) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end
                end

                S_GAP: begin
                    // A stray strobe means the controller is not where we think;
                    // resynchronise rather than issue into an active burst.
                    if (any_strobe) begin
                        cnt_q   <= '0;
                        state_q <= S_SYNC;
                    end else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    grant_q <= '0;
                    state_q <= S_SYNC;
                end
            endcase
        end
    end

    assign bus.req_ack      = ack_q;
    assign bus.req_done     = done_q;
    assign bus.err          = err_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.sys_CMD      = cmd_q;
    assign bus.sys_ADDR     = addr_q;
    assign bus.sys_DIN      = din_mux;
    assign bus.dout         = bus.sys_DOUT;
    assign bus.req_rd_valid = grant_q & {NREQ{bus.sys_rd_data_valid}};
    assign bus.req_wr_valid = grant_q & {NREQ{bus.sys_wr_data_valid}};

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_arbiter
// Self-checking bench for sram_burst_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge. Expected grants come from a fixed vector
// table and from a round-robin reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_sram_burst_arbiter;
    localparam int NREQ          = 3;
    localparam int QUIET         = 8;
    localparam int START_TIMEOUT = 8;
    localparam int GAP_CYCLES    = 2;

    logic sys_CLK = 1'b0;
    logic sys_RST;

    always #5 sys_CLK = ~sys_CLK;

    sram_burst_arbiter_if #(.NREQ(NREQ)) bus ();

    sram_burst_arbiter #(
        .NREQ          (NREQ),
        .QUIET         (QUIET),
        .START_TIMEOUT (START_TIMEOUT),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .sys_CLK (sys_CLK),
        .sys_RST (sys_RST),
        .bus     (bus)
    );

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] wr;
        logic [NREQ-1:0] ack;
        logic [1:0]      cmd;
        int              lat;
        int              beats;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          model_ptr;
    logic [18:0] addr_tab [NREQ];
    vec_t        vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge sys_CLK);
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] oh);
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

    // Reference arbitration: requester 0 wins outright, otherwise the first
    // requesting index visiting model_ptr, model_ptr+1, ... within 1..NREQ-1.
    function automatic logic [NREQ-1:0] predict(input logic [NREQ-1:0] r);
        logic [NREQ-1:0] g;
        int c;
        g = '0;
        if (r[0]) begin
            g[0] = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                c = (model_ptr - 1 + k) % (NREQ - 1) + 1;
                if (r[c]) begin
                    g[c] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    task automatic advance_ptr(input int win);
        if (win != 0) model_ptr = (win == NREQ - 1) ? 1 : win + 1;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < NREQ; i++) bus.req_addr[19*i +: 19] = addr_tab[i];
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            cyc();
            n++;
        end
        if (bus.busy !== 1'b0) check({name, " wait idle"}, 32'(bus.busy), 0);
    endtask

    // Drives `beats` strobes after `lat` extra quiet START cycles and checks
    // routing on every beat, then the done pulse. Returns at the done sample.
    task automatic beats_phase(input string name, input int lat, input int beats,
                               input int win, input logic wr);
        logic [NREQ-1:0] oh;
        logic [15:0]     dv;
        int              bad;
        oh  = '0;
        oh[win] = 1'b1;
        bad = 0;
        repeat (lat) cyc();
        for (int b = 0; b < beats; b++) begin
            dv = 16'($urandom);
            bus.sys_DOUT = dv;
            bus.req_din[16*win +: 16] = 16'(b);
            if (wr) bus.sys_wr_data_valid = 1'b1;
            else    bus.sys_rd_data_valid = 1'b1;
            #1;
            if (bus.req_rd_valid !== (wr ? '0 : oh)) bad++;
            if (bus.req_wr_valid !== (wr ? oh : '0)) bad++;
            if (bus.sys_DIN !== 16'(b)) bad++;
            if (bus.dout !== dv) bad++;
            cyc();
        end
        bus.sys_rd_data_valid = 1'b0;
        bus.sys_wr_data_valid = 1'b0;
        check({name, " beat routing"}, bad, 0);
        cyc();
        check({name, " done"}, 32'(bus.req_done), 32'(oh));
        check({name, " din after done"}, 32'(bus.sys_DIN), 0);
    endtask

    task automatic txn(input string name, input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                       input int lat, input int beats,
                       input logic [NREQ-1:0] exp_ack, input logic [1:0] exp_cmd);
        int win;
        win = oh2idx(exp_ack);
        wait_idle(name);
        for (int i = 0; i < NREQ; i++) bus.req_din[16*i +: 16] = 16'hA5A0 + 16'(i);
        bus.req_wr = w;
        bus.req    = r;
        cyc();
        check({name, " ack"}, 32'(bus.req_ack), 32'(exp_ack));
        check({name, " cmd"}, 32'(bus.sys_CMD), 32'(exp_cmd));
        check({name, " addr"}, 32'(bus.sys_ADDR), 32'(addr_tab[win]));
        bus.req = '0;
        cyc();
        check({name, " cmd width"}, 32'(bus.sys_CMD), 0);
        beats_phase(name, lat, beats, win, w[win]);
        advance_ptr(win);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int bad_tail;
        logic [NREQ-1:0] r, w, g;

        // Arbitration vectors; grants assume the pointer state left by the
        // preceding rows, starting from the reset value 1.
        vecs[0] = '{req:3'b001, wr:3'b000, ack:3'b001, cmd:2'b11, lat:1, beats:4};
        vecs[1] = '{req:3'b110, wr:3'b010, ack:3'b010, cmd:2'b01, lat:0, beats:3};
        vecs[2] = '{req:3'b110, wr:3'b000, ack:3'b100, cmd:2'b11, lat:2, beats:5};
        vecs[3] = '{req:3'b111, wr:3'b111, ack:3'b001, cmd:2'b01, lat:3, beats:2};
        vecs[4] = '{req:3'b100, wr:3'b100, ack:3'b100, cmd:2'b01, lat:0, beats:1};
        vecs[5] = '{req:3'b010, wr:3'b000, ack:3'b010, cmd:2'b11, lat:1, beats:6};
        vecs[6] = '{req:3'b010, wr:3'b010, ack:3'b010, cmd:2'b01, lat:4, beats:3};
        vecs[7] = '{req:3'b110, wr:3'b100, ack:3'b100, cmd:2'b01, lat:0, beats:2};
        vecs[8] = '{req:3'b011, wr:3'b000, ack:3'b001, cmd:2'b11, lat:2, beats:4};
        vecs[9] = '{req:3'b110, wr:3'b000, ack:3'b010, cmd:2'b11, lat:1, beats:3};

        // ---- Reset behaviour and SYNC quiet period ----
        sys_RST               = 1'b1;
        bus.req               = '0;
        bus.req_wr            = '0;
        bus.req_addr          = '0;
        bus.req_din           = '0;
        bus.sys_DOUT          = '0;
        bus.sys_wr_data_valid = 1'b0;
        bus.sys_rd_data_valid = 1'b1;
        model_ptr             = 1;
        addr_tab[0] = 19'h01111;
        addr_tab[1] = 19'h22222;
        addr_tab[2] = 19'h73333;
        set_addrs();
        repeat (2) cyc();
        #1;
        check("rst busy", 32'(bus.busy), 1);
        check("rst cmd", 32'(bus.sys_CMD), 0);
        check("rst addr", 32'(bus.sys_ADDR), 0);
        check("rst ack", 32'(bus.req_ack), 0);
        check("rst done", 32'(bus.req_done), 0);
        check("rst err", 32'(bus.err), 0);
        check("rst rd route", 32'(bus.req_rd_valid), 0);
        check("rst din", 32'(bus.sys_DIN), 0);
        bus.sys_rd_data_valid = 1'b0;
        cyc();
        sys_RST = 1'b0;
        bad = 0;
        for (int k = 1; k <= QUIET + 1; k++) begin
            cyc();
            if (bus.sys_CMD !== 2'b00) bad++;
            if (k == QUIET) check("sync busy at quiet", 32'(bus.busy), 1);
        end
        check("sync busy fall", 32'(bus.busy), 0);
        check("sync cmd quiet", bad, 0);

        // ---- Table-driven arbitration ----
        for (int v = 0; v < 10; v++) begin
            txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].wr, vecs[v].lat,
                vecs[v].beats, vecs[v].ack, vecs[v].cmd);
        end

        // ---- Full 128-beat read for requester 0 and the idle gap ----
        addr_tab[0] = 19'h12345;
        set_addrs();
        txn("rd128", 3'b001, 3'b000, 1, 128, 3'b001, 2'b11);
        bus.req_wr = '0;
        bus.req    = 3'b001;
        cyc();
        n = 1;
        check("rd128 done pulse", 32'(bus.req_done), 0);
        while (bus.sys_CMD === 2'b00 && n < 20) begin
            cyc();
            n++;
        end
        // Two GAP cycles plus the IDLE cycle in which the command is registered.
        check("gap to next cmd", n, GAP_CYCLES + 1);
        check("gap next cmd", 32'(bus.sys_CMD), 32'(2'b11));
        check("gap next ack", 32'(bus.req_ack), 32'(3'b001));
        bus.req = '0;
        cyc();
        beats_phase("gap burst", 0, 2, 0, 1'b0);

        // ---- Write burst from requester 2 ----
        txn("wr2", 3'b100, 3'b100, 1, 16, 3'b100, 2'b01);

        // ---- Held 110 alternates, then 111 goes to requester 0 ----
        txn("rr a", 3'b110, 3'b000, 0, 2, 3'b010, 2'b11);
        txn("rr b", 3'b110, 3'b000, 0, 2, 3'b100, 2'b11);
        txn("rr c", 3'b110, 3'b000, 0, 2, 3'b010, 2'b11);
        txn("rr d", 3'b110, 3'b000, 0, 2, 3'b100, 2'b11);
        txn("pri0", 3'b111, 3'b000, 0, 2, 3'b001, 2'b11);

        // ---- Start timeout ----
        wait_idle("tmo");
        bus.req_wr = '0;
        bus.req    = 3'b010;
        cyc();
        check("tmo ack", 32'(bus.req_ack), 32'(3'b010));
        bus.req = '0;
        advance_ptr(1);
        bad = 0;
        for (int k = 1; k < START_TIMEOUT; k++) begin
            cyc();
            if (bus.err !== 1'b0) bad++;
        end
        check("tmo no early err", bad, 0);
        cyc();
        check("tmo err", 32'(bus.err), 1);
        check("tmo busy", 32'(bus.busy), 1);
        bus.sys_rd_data_valid = 1'b1;
        #1;
        check("tmo grant cleared", 32'(bus.req_rd_valid), 0);
        cyc();
        bus.sys_rd_data_valid = 1'b0;
        check("tmo err pulse", 32'(bus.err), 0);
        n = 0;
        bad = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            cyc();
            n++;
            if (bus.busy === 1'b1 && n > 0 && bus.sys_CMD !== 2'b00) bad++;
        end
        check("tmo resync cycles", n, QUIET + 1);
        check("tmo resync cmd", bad, 0);

        // ---- Randomised traffic against the reference model ----
        for (int t = 0; t < 40; t++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) addr_tab[i] = 19'($urandom);
            set_addrs();
            g = predict(r);
            txn($sformatf("rnd%0d", t), r, w, $urandom_range(0, 4), $urandom_range(1, 6),
                g, w[oh2idx(g)] ? 2'b01 : 2'b11);
        end

        // ---- Reset at beat 40 of a read; tail must be absorbed ----
        addr_tab[0] = 19'h5A5A5;
        set_addrs();
        wait_idle("rstb");
        bus.req_wr = '0;
        bus.req    = 3'b001;
        cyc();
        check("rstb ack", 32'(bus.req_ack), 32'(3'b001));
        bus.req = '0;
        cyc();
        bad      = 0;
        bad_tail = 0;
        for (int b = 0; b < 128; b++) begin
            bus.sys_rd_data_valid = 1'b1;
            if (b == 50) bus.req = 3'b010;
            if (b == 39) begin
                sys_RST = 1'b1;
                #1;
                check("rstb busy", 32'(bus.busy), 1);
                check("rstb cmd", 32'(bus.sys_CMD), 0);
                check("rstb addr", 32'(bus.sys_ADDR), 0);
                check("rstb rd route", 32'(bus.req_rd_valid), 0);
            end else begin
                #1;
                if (b < 39 && bus.req_rd_valid !== 3'b001) bad++;
                if (b > 39 && bus.req_rd_valid !== 3'b000) bad_tail++;
                if (b > 39 && (bus.sys_CMD !== 2'b00 || bus.req_ack !== 3'b000)) bad_tail++;
            end
            cyc();
            if (b == 39) sys_RST = 1'b0;
        end
        bus.sys_rd_data_valid = 1'b0;
        model_ptr = 1;
        check("rstb head routed", bad, 0);
        check("rstb tail blocked", bad_tail, 0);
        n = 0;
        while (bus.sys_CMD === 2'b00 && n < 40) begin
            cyc();
            n++;
        end
        // QUIET+1 strobe-free SYNC cycles, then one IDLE cycle to issue.
        check("rstb quiet to cmd", n, QUIET + 2);
        check("rstb next ack", 32'(bus.req_ack), 32'(3'b010));
        check("rstb next addr", 32'(bus.sys_ADDR), 32'(addr_tab[1]));
        bus.req = '0;
        cyc();
        beats_phase("rstb burst", 0, 3, 1, 1'b0);
        advance_ptr(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
